regulator_trim_ctrl: RTL

- Digital trim calibration controller for an array of NUM_CH behavioural regulators, each with a signed trim input.
- Per channel it runs a TRIM_W-bit successive-approximation (SAR) search against a comparator flag, cmp_hi[ch] (1 = vout above target). It can then optionally keep tracking with ±1 LSB steps.
- All channels run in parallel on shared timing.
- Sits between the testbench top (which drives the comparator flags from the analog probe) and the regulators' trim ports. Higher trim gives higher vout.

---
 rtl/regulator_trim_ctrl_if.sv | 28 ++
 rtl/regulator_trim_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/regulator_trim_ctrl_if.sv
// Handshake and data bundle between the trim controller and the regulator
// array / comparator front end.
interface regulator_trim_ctrl_if #(
   parameter int NUM_CH = 2,
   parameter int TRIM_W = 4
);
   logic                     start;
   logic                     mode;
   logic [NUM_CH-1:0]        cmp_hi;
   logic [NUM_CH*TRIM_W-1:0] trim;
   logic                     busy;
   logic                     tracking;
   logic                     done;
   logic [NUM_CH-1:0]        locked;
   logic [NUM_CH-1:0]        sat;

   // Stimulus side: issues start/mode and returns comparator flags.
   modport master (
      output start, mode, cmp_hi,
      input  trim, busy, tracking, done, locked, sat
   );

   // Controller side.
   modport slave (
      input  start, mode, cmp_hi,
      output trim, busy, tracking, done, locked, sat
   );
endinterface

// File: rtl/regulator_trim_ctrl.sv
// Trim calibration controller: per-channel SAR search of a signed trim code
// against a comparator flag, optionally followed by +/-1 LSB tracking.
// All channels share one settle counter and one bit index.
module regulator_trim_ctrl #(
   parameter int NUM_CH        = 2,
   parameter int TRIM_W        = 4,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   regulator_trim_ctrl_if.slave tc
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int BIT_W = (TRIM_W > 2) ? $clog2(TRIM_W) : 1;

   localparam logic [CNT_W-1:0]         CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [BIT_W-1:0]         BIT_TOP    = BIT_W'(TRIM_W - 1);
   localparam logic [TRIM_W-1:0]        MSB_MASK   = {1'b1, {(TRIM_W-1){1'b0}}};
   localparam logic signed [TRIM_W-1:0] TRIM_MAX   = {1'b0, {(TRIM_W-1){1'b1}}};
   localparam logic signed [TRIM_W-1:0] TRIM_MIN   = {1'b1, {(TRIM_W-1){1'b0}}};
   localparam logic signed [TRIM_W-1:0] TRIM_ONE   = TRIM_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_SAR, S_TRACK} state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [BIT_W-1:0]           bit_q, bit_d;
   logic                       mode_q, mode_d;
   logic                       busy_q, busy_d;
   logic                       tracking_q, tracking_d;
   logic                       done_q, done_d;
   logic [NUM_CH-1:0]          locked_q, locked_d;
   logic [NUM_CH-1:0]          sat_q, sat_d;
   // Last tracking step direction (1 = down) and whether one has been taken.
   logic [NUM_CH-1:0]          dir_q, dir_d;
   logic [NUM_CH-1:0]          dvld_q, dvld_d;
   logic signed [TRIM_W-1:0]   trim_q [NUM_CH];
   logic signed [TRIM_W-1:0]   trim_d [NUM_CH];
   logic [TRIM_W-1:0]          oc;
   logic [NUM_CH*TRIM_W-1:0]   trim_flat;

   // True when a step in the requested direction would leave the trim range.
   function automatic logic at_limit(input logic signed [TRIM_W-1:0] t, input logic down);
      return down ? (t == TRIM_MIN) : (t == TRIM_MAX);
   endfunction

   // Saturating +/-1 step; holds the code at either end of the range.
   function automatic logic signed [TRIM_W-1:0] step_trim(input logic signed [TRIM_W-1:0] t,
                                                          input logic down);
      if (at_limit(t, down)) return t;
      return down ? (t - TRIM_ONE) : (t + TRIM_ONE);
   endfunction

   // Next-state and output decode for the IDLE / SAR / TRACK controller.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      mode_d     = mode_q;
      busy_d     = busy_q;
      tracking_d = tracking_q;
      done_d     = 1'b0;
      locked_d   = locked_q;
      sat_d      = sat_q;
      dir_d      = dir_q;
      dvld_d     = dvld_q;
      oc         = '0;
      for (int ch = 0; ch < NUM_CH; ch++) trim_d[ch] = trim_q[ch];

      if (state_q == S_SAR) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            // SAR works on the offset-binary view: trim with its MSB inverted.
            for (int ch = 0; ch < NUM_CH; ch++) begin
               oc = trim_q[ch] ^ MSB_MASK;
               if (tc.cmp_hi[ch]) oc[bit_q] = 1'b0;
               if (bit_q != '0) oc[bit_q - BIT_W'(1)] = 1'b1;
               trim_d[ch] = oc ^ MSB_MASK;
               if (bit_q == '0) sat_d[ch] = at_limit(trim_d[ch], tc.cmp_hi[ch]);
            end
            cnt_d = CNT_RELOAD;
            if (bit_q != '0) begin
               bit_d = bit_q - BIT_W'(1);
            end else begin
               done_d     = 1'b1;
               busy_d     = 1'b0;
               locked_d   = '1;
               dvld_d     = '0;
               tracking_d = mode_q;
               state_d    = mode_q ? S_TRACK : S_IDLE;
            end
         end
      end else begin
         if (tc.start) begin
            // Fresh search from mid-scale; also used to restart out of TRACK.
            state_d    = S_SAR;
            busy_d     = 1'b1;
            tracking_d = 1'b0;
            locked_d   = '0;
            sat_d      = '0;
            dvld_d     = '0;
            mode_d     = tc.mode;
            bit_d      = BIT_TOP;
            cnt_d      = CNT_RELOAD;
            for (int ch = 0; ch < NUM_CH; ch++) trim_d[ch] = '0;
         end else if (state_q == S_TRACK) begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               cnt_d = CNT_RELOAD;
               for (int ch = 0; ch < NUM_CH; ch++) begin
                  sat_d[ch]  = at_limit(trim_q[ch], tc.cmp_hi[ch]);
                  trim_d[ch] = step_trim(trim_q[ch], tc.cmp_hi[ch]);
                  // A reversal means we are dithering around the target.
                  if (dvld_q[ch]) locked_d[ch] = (dir_q[ch] != tc.cmp_hi[ch]);
                  dir_d[ch]  = tc.cmp_hi[ch];
                  dvld_d[ch] = 1'b1;
               end
            end
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         mode_q     <= 1'b0;
         busy_q     <= 1'b0;
         tracking_q <= 1'b0;
         done_q     <= 1'b0;
         locked_q   <= '0;
         sat_q      <= '0;
         dir_q      <= '0;
         dvld_q     <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) trim_q[ch] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         mode_q     <= mode_d;
         busy_q     <= busy_d;
         tracking_q <= tracking_d;
         done_q     <= done_d;
         locked_q   <= locked_d;
         sat_q      <= sat_d;
         dir_q      <= dir_d;
         dvld_q     <= dvld_d;
         for (int ch = 0; ch < NUM_CH; ch++) trim_q[ch] <= trim_d[ch];
      end
   end

   // Pack the per-channel trim registers onto the output bus.
   always_comb begin
      trim_flat = '0;
      for (int ch = 0; ch < NUM_CH; ch++) trim_flat[ch*TRIM_W +: TRIM_W] = trim_q[ch];
   end

   assign tc.trim     = trim_flat;
   assign tc.busy     = busy_q;
   assign tc.tracking = tracking_q;
   assign tc.done     = done_q;
   assign tc.locked   = locked_q;
   assign tc.sat      = sat_q;

endmodule
